// File: rtl/pipe_pkg.sv
// +--------------------------------------------------------------------+
// | pipe_pkg : shared widths, NOP encoding and entry type for stages  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int INSTR_W_DEF = 32;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } pipe_entry_t;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_perf.sv
// +--------------------------------------------------------------------+
// | pipe_stage_perf : saturating stall / flush event counters          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module pipe_stage_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall_evt,
    input  logic        i_flush_evt,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_count
);

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (i_stall_evt && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (i_flush_evt && (flush_cnt_q != 32'hFFFF_FFFF))
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cycles = stall_cnt_q;
    assign o_flush_count  = flush_cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// +--------------------------------------------------------------------+
// | pipe_stage_buf : elastic {pc,instr} stage with skid FIFO,          |
// | stall and flush. Perf counters enabled by PIPE_STAGE_PERF_EN.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = INSTR_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    input  logic [PC_W-1:0]          i_pc,
    input  logic [DATA_W-1:0]        i_instr,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [PC_W-1:0]          o_pc,
    output logic [DATA_W-1:0]        o_instr,
    input  logic                     i_ready,
    input  logic                     i_stall,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [31:0]              o_stall_cycles,
    output logic [31:0]              o_flush_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

    generate
        if (DEPTH != 1 && DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
            $error("pipe_stage_buf: DEPTH must be 1, 2 or 4");
        end
    endgenerate

    logic [PC_W-1:0]   pc_mem_q    [DEPTH];
    logic [DATA_W-1:0] instr_mem_q [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             push, pop, not_empty;

    assign not_empty = (count_q != '0);
    assign o_ready   = (count_q < DEPTH_CNT);
    assign o_valid   = not_empty && !i_stall;
    assign o_pc      = not_empty ? pc_mem_q[rd_ptr_q]    : '0;
    assign o_instr   = not_empty ? instr_mem_q[rd_ptr_q] : '0;
    assign o_count   = count_q;

    // Flush suppresses both sides so the killed head is never counted as consumed.
    assign push = i_valid && o_ready && !i_flush;
    assign pop  = o_valid && i_ready && !i_flush;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push)
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= i_pc;
            instr_mem_q[wr_ptr_q] <= i_instr;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic stall_evt, flush_evt;
    assign stall_evt = i_stall && not_empty;
    assign flush_evt = i_flush && not_empty;

    pipe_stage_perf u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_stall_evt    (stall_evt),
        .i_flush_evt    (flush_evt),
        .o_stall_cycles (o_stall_cycles),
        .o_flush_count  (o_flush_count)
    );
`else
    assign o_stall_cycles = '0;
    assign o_flush_count  = '0;
`endif

    a_hold_payload: assert property (@(posedge clk) disable iff (!rst_n)
        (i_valid && !o_ready && !i_flush) |=> ($stable(i_pc) && $stable(i_instr)));

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (count_q <= DEPTH_CNT));

endmodule

`default_nettype wire

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised elastic pipeline stage placed between Fetch, Decode and Execute.
- Replaces the bare per-stage PC/instruction hand-off with valid/ready handshakes, a DEPTH-entry skid FIFO, and explicit stall/flush control.
- Carries {pc, instr} per entry.
- Flush kills all buffered and incoming work; stall freezes the output side without losing data.

Parameters:
- DATA_W, 32, instruction/payload width.
- PC_W, 32, program-counter width.
- DEPTH, 2, number of buffered entries. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream entry present.
- i_pc  in  PC_W  upstream PC.
- i_instr  in  DATA_W  upstream instruction.
- o_ready  out  1  stage can accept a push this cycle.
- o_valid  out  1  head entry presented downstream.
- o_pc  out  PC_W  head PC.
- o_instr  out  DATA_W  head instruction.
- i_ready  in  1  downstream accepts the head.
- i_stall  in  1  freeze the output side.
- i_flush  in  1  discard all entries.
- o_count  out  $clog2(DEPTH)+1  current occupancy.
- o_stall_cycles  out  32  perf counter (see Optional Feature).
- o_flush_count  out  32  perf counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - count=0, read/write pointers=0, o_valid=0, o_pc=0, o_instr=0.
  - Perf counters =0.
- o_ready = (count < DEPTH).
  - Purely a function of registered occupancy; no combinational path from i_ready or i_stall.
- o_valid = (count != 0) && !i_stall.
- o_pc / o_instr always show the head entry. They read 0 when count==0.
- push = i_valid && o_ready && !i_flush.
- pop = o_valid && i_ready.
- Same-cycle push and pop: both occur, count unchanged, pointers advance, FIFO order preserved.
- Throughput:
  - DEPTH=1: an entry cannot be accepted while full, even if popped that cycle, so sustained rate is 1 per 2 cycles.
  - DEPTH>=2: sustained rate is 1 per cycle.
- Latency: an entry pushed in cycle N is visible on o_valid in cycle N+1, provided it is the head and there is no stall.
- i_flush=1:
  - Next edge: count=0 and pointers=0.
  - Any same-cycle push is dropped and no pop is counted.
  - o_valid still reflects the pre-flush contents during the flush cycle; downstream must qualify with its own flush.
- i_stall=1:
  - o_valid forced 0, so no pop.
  - Pushes continue while o_ready=1, so the buffer may fill.
  - Contents retained.
- i_stall and i_flush together: flush wins.
- Pointer wrap: modulo DEPTH. DEPTH is a power of two, so natural wrap applies.
- Reset asserted mid-transfer: all state clears immediately and the in-flight handshake is lost. No partial entry survives.
- Protocol assertions (simulation only):
  - i_pc and i_instr are stable while i_valid=1 && o_ready=0.
  - count never exceeds DEPTH.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - o_stall_cycles increments each cycle with i_stall=1 && count!=0.
  - o_flush_count increments each cycle with i_flush=1 && count!=0.
  - Both are 32-bit, saturate at 32'hFFFF_FFFF and clear only on reset.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package pipe_pkg holds:
  - PC_W_DEF=32 and INSTR_W_DEF=32.
  - NOP_INSTR=32'h0000_0013.
  - A packed struct pipe_entry_t {pc, instr}.
- One natural sub-module: pipe_stage_perf, the saturating counter pair, instantiated only under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset check: rst_n=0 mid-cycle -> o_valid=0, o_count=0 and o_pc=0 asynchronously.
- Streaming, DEPTH=2: push PCs 0x0, 0x4, 0x8 back-to-back with i_ready=1 -> o_pc sequence 0x0, 0x4, 0x8 on consecutive cycles starting 1 cycle after the first push, and o_ready stays 1.
- Stall fill, DEPTH=2: i_stall=1, push 0x10 and 0x14 -> o_count=2, o_ready=0, o_valid=0. Release the stall -> 0x10 then 0x14 pop in order.
- Flush with simultaneous push: count=2 and push of 0x20 with i_flush=1 -> next cycle count=0, o_valid=0, and 0x20 never appears.
- DEPTH=1 throughput: continuous i_valid with i_ready=1 -> one acceptance every 2 cycles. DEPTH=4 with i_ready=0 -> accepts exactly 4, then o_ready=0.
- With PIPE_STAGE_PERF_EN: 5 cycles of stall while count=1, then 1 flush cycle -> o_stall_cycles=5 and o_flush_count=1. Without the macro -> both read 0.
